muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer sitting beside the single-cycle ALU in the execute stage. It accepts one operation per `start` pulse from the control unit and runs a 32-iteration shift-add multiply or restoring divide on magnitudes, then applies a sign fix. It holds `busy` high so the pipeline stalls, and returns the 32-bit result with a one-cycle `done` pulse. Divide-by-zero and signed overflow take a fast path.

---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the execute-stage control unit and the
// iterative RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand1, operand2, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, operand1, operand2, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or
// restoring divide on operand magnitudes, followed by a sign-fix cycle.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [2:0]        op_q;     // latched funct3
    logic              sign1_q;  // dividend/multiplicand was negative
    logic              neg_q;    // operand signs differ
    logic [XLEN-1:0]   mcand_q;  // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q;    // mul: {hi, multiplier/lo}; div: {rem, quot}
    logic [4:0]        cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Request decode: operand signedness, magnitudes and fast-path detection
    logic            is_div_in;
    logic            sgn1_in;
    logic            sgn2_in;
    logic [XLEN-1:0] mag1_in;
    logic [XLEN-1:0] mag2_in;
    logic            div0_in;
    logic            ovf_in;
    logic [XLEN-1:0] fast_res_in;

    always_comb begin
        is_div_in = bus.funct3[2];
        sgn1_in   = 1'b0;
        sgn2_in   = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn1_in = bus.operand1[XLEN-1];
                sgn2_in = bus.operand2[XLEN-1];
            end
            3'b010: begin
                sgn1_in = bus.operand1[XLEN-1];
            end
            default: begin
                sgn1_in = 1'b0;
                sgn2_in = 1'b0;
            end
        endcase
        mag1_in = sgn1_in ? ('0 - bus.operand1) : bus.operand1;
        mag2_in = sgn2_in ? ('0 - bus.operand2) : bus.operand2;

        div0_in = is_div_in && (bus.operand2 == '0);
        ovf_in  = is_div_in && !bus.funct3[0] &&
                  (bus.operand1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (bus.operand2 == '1);

        // funct3[1] selects remainder over quotient for divide ops
        fast_res_in = '0;
        if (div0_in) begin
            fast_res_in = bus.funct3[1] ? bus.operand1 : '1;
        end else if (ovf_in) begin
            fast_res_in = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of the multiply and divide datapaths, plus the sign fix
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                            : {1'b0, acc_q[2*XLEN-1:1]};

        // remainder stays below the divisor, so the shifted value fits XLEN+1 bits
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

        prod_fix = neg_q   ? ('0 - acc_q) : acc_q;
        quot_fix = neg_q   ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_fix  = sign1_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quot_fix;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                           : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            sign1_q  <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.kill) begin
                        op_q    <= bus.funct3;
                        sign1_q <= sgn1_in;
                        neg_q   <= sgn1_in ^ sgn2_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        if (is_div_in) begin
                            mcand_q <= mag2_in;
                            acc_q   <= {{XLEN{1'b0}}, mag1_in};
                        end else begin
                            mcand_q <= mag1_in;
                            acc_q   <= {{XLEN{1'b0}}, mag2_in};
                        end
                        if (div0_in || ovf_in) begin
                            result_q <= fast_res_in;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.kill) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        acc_q <= op_q[2] ? div_next : mul_next;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.kill) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized ops
// against an arithmetic reference model, and kill/reset/start-while-busy cases.
module tb_muldiv_seq;
    logic clk;
    logic rst_n;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit / 32-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = '0;
        r  = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = 32'(ia / ib);
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else r = 32'(ia % ib);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 34;
    endfunction

    // Issue one op, scramble the inputs after the start edge, and check
    // result, done latency, busy duration and the return to idle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        int busy_cnt;
        bit seen;
        logic [31:0] got;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = f3;
        bus.operand1 = a;
        bus.operand2 = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.operand1 = $urandom;
        bus.operand2 = $urandom;
        seen = 0;
        lat = 0;
        busy_cnt = 0;
        got = 'x;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1;
                lat = k + 1;
                got = bus.result;
            end
        end
        if (!seen) $display("FAIL %s timeout: no done within 40 cycles", name);
        check({name, " result"}, got, exp);
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy cycles"}, busy_cnt, exp_lat);
        @(posedge clk);
        #1;
        check({name, " idle after"}, {30'b0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, prior, got;
        logic [2:0]  f3;
        int ndone;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
        vecs[13] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{3'd1, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 34};
        vecs[15] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};

        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.funct3   = '0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        rst_n = 1'b0;
        #12;
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                4: b = $urandom_range(1, 15);
                default: ;
            endcase
            run_op(f3, a, b, model(f3, a, b), model_lat(f3, a, b), $sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b));
        end

        // kill at cycle 10 of a DIV: no done, result holds, then MUL 3x4
        run_op(3'd0, 32'd6, 32'd7, 32'd42, 34, "pre-kill mul");
        prior = 32'd42;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.operand1 = 32'd1000; bus.operand2 = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        if (bus.done) ndone++;
        check("kill busy", {31'b0, bus.busy}, 32'd0);
        check("kill result held", bus.result, prior);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("kill no done", ndone, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "post-kill mul");

        // kill together with start in IDLE drops the request
        @(negedge clk);
        bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'd5; bus.operand1 = 32'd9; bus.operand2 = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        check("kill+start busy", {31'b0, bus.busy}, 32'd0);
        check("kill+start done", {31'b0, bus.done}, 32'd0);
        check("kill+start result", bus.result, 32'd12);

        // start while busy is ignored: one done, first op's result
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd3; bus.operand1 = 32'h12345678; bus.operand2 = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        got = '0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 4) begin
                bus.start = 1'b1; bus.funct3 = 3'd5; bus.operand1 = 32'd1; bus.operand2 = 32'd0;
            end
            if (k == 5) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                got = bus.result;
            end
        end
        check("busy start done count", ndone, 32'd1);
        check("busy start result", got, model(3'd3, 32'h12345678, 32'h9ABCDEF0));

        // asynchronous reset mid-CALC clears outputs immediately
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.operand1 = 32'd9; bus.operand2 = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst busy", {31'b0, bus.busy}, 32'd0);
        check("async rst done", {31'b0, bus.done}, 32'd0);
        check("async rst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "post-reset divu");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
